// File: rtl/div_pkg.sv
// Shared types and helpers for the programmable clock divider.
package div_pkg;

  typedef enum logic [1:0] {IDLE, HIGH, LOW} div_state_t;

  localparam int MIN_DIV = 2;

  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
  } half_t;

  // hi = ceil(n/2) written without n+1 so the widest divisor cannot overflow
  function automatic half_t half_lengths(input logic [31:0] n);
    half_t h;
    h.lo = n >> 1;
    h.hi = (n >> 1) + {31'd0, n[0]};
    return h;
  endfunction

endpackage

// File: rtl/div_prog_ctrl_reg.sv
// Divisor registers: validates loads, holds pending/current divisor, pulses div_ack/div_err.
module div_prog_ctrl_reg
  import div_pkg::*;
#(
  parameter int CNT_W       = 16,
  parameter int DEFAULT_DIV = 50
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [CNT_W-1:0] div_val,
  input  logic             div_load,
  input  logic             idle,
  input  logic             boundary,
  output logic [CNT_W-1:0] cur_div,
  output logic             div_ack,
  output logic             div_err
);

  logic [CNT_W-1:0] pend;
  logic             pend_v;
  logic             valid;

  assign valid = div_val >= CNT_W'(MIN_DIV);

  always_ff @(posedge clk) begin
    if (rst) begin
      cur_div <= CNT_W'(DEFAULT_DIV);
      pend    <= '0;
      pend_v  <= 1'b0;
      div_ack <= 1'b0;
      div_err <= 1'b0;
    end else begin
      div_ack <= 1'b0;
      div_err <= div_load && !valid;
      if (idle) begin
        // A fresh load beats a leftover pending value (loaded on the final boundary).
        if (div_load && valid) begin
          cur_div <= div_val;
          div_ack <= 1'b1;
        end else if (pend_v) begin
          cur_div <= pend;
          div_ack <= 1'b1;
        end
        pend_v <= 1'b0;
      end else begin
        if (boundary && pend_v) begin
          cur_div <= pend;
          div_ack <= 1'b1;
          pend_v  <= 1'b0;
        end
        // Written after the apply so a load on the boundary waits for the next one.
        if (div_load && valid) begin
          pend   <= div_val;
          pend_v <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/div_prog.sv
// Programmable clock divider with near-50% duty; optional period counter under DIV_PROG_PERIOD_CNT_EN.
module div_prog
  import div_pkg::*;
#(
  parameter int CNT_W       = 16,
  parameter int DEFAULT_DIV = 50,
  parameter bit START_EN    = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [CNT_W-1:0] div_val,
  input  logic             div_load,
  output logic             div_ack,
  output logic             div_err,
  output logic             clk_div,
  output logic             tick,
  output logic             busy,
  output logic [CNT_W-1:0] cur_div
`ifdef DIV_PROG_PERIOD_CNT_EN
  ,
  output logic [31:0]      period_cnt,
  input  logic             period_clr
`endif
);

  div_state_t       state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic             start_q;
  logic             go;
  logic             boundary;
  half_t            h;

  assign h    = half_lengths(32'(cur_div));
  assign go   = en | start_q;
  assign busy = (state != IDLE);

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    boundary = 1'b0;
    case (state)
      IDLE: begin
        if (go) begin
          state_nx = HIGH;
          cnt_nx   = '0;
        end
      end
      HIGH: begin
        if (32'(cnt) == h.hi - 32'd1) begin
          state_nx = LOW;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt + CNT_W'(1);
        end
      end
      LOW: begin
        if (32'(cnt) == h.lo - 32'd1) begin
          boundary = 1'b1;
          state_nx = go ? HIGH : IDLE;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt + CNT_W'(1);
        end
      end
      default: begin
        state_nx = IDLE;
        cnt_nx   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      clk_div <= 1'b0;
      tick    <= 1'b0;
      start_q <= START_EN;
    end else begin
      state   <= state_nx;
      cnt     <= cnt_nx;
      clk_div <= (state_nx == HIGH);
      // Low phase is never empty, so HIGH after non-HIGH marks a new period.
      tick    <= (state_nx == HIGH) && (state != HIGH);
      if (en) start_q <= 1'b0;
    end
  end

  div_prog_ctrl_reg #(
    .CNT_W       (CNT_W),
    .DEFAULT_DIV (DEFAULT_DIV)
  ) u_ctrl (
    .clk      (clk),
    .rst      (rst),
    .div_val  (div_val),
    .div_load (div_load),
    .idle     (state == IDLE),
    .boundary (boundary),
    .cur_div  (cur_div),
    .div_ack  (div_ack),
    .div_err  (div_err)
  );

`ifdef DIV_PROG_PERIOD_CNT_EN
  always_ff @(posedge clk) begin
    if (rst || period_clr) period_cnt <= '0;
    else if (boundary)     period_cnt <= period_cnt + 32'd1;
  end
`endif

endmodule

// File: doc/div_prog.md
Name: div_prog

Overview:
- Parametrised successor to the fixed terminal-count clock divider.
- Generates a registered divided clock `clk_div` from `clk`; the divisor is programmable at runtime through a load handshake.
- Even and odd ratios are both supported, with near-50% duty; a rate change takes effect glitch-free at a period boundary.
- Sits at the clock-generation edge of the divider subsystem and feeds downstream strobe/clock-enable consumers.

Parameters:
- CNT_W, 16, width of divisor and internal counters.
- DEFAULT_DIV, 50, divisor loaded at reset; must satisfy 2 <= DEFAULT_DIV < 2^CNT_W.
- START_EN, 0, value of internal run request out of reset (1 = free-run immediately).

Ports:
- clk  in  1  single clock.
- rst  in  1  synchronous, active-high reset.
- en  in  1  run request; level-sensitive.
- div_val  in  CNT_W  requested divisor N.
- div_load  in  1  one-cycle strobe; samples div_val.
- div_ack  out  1  one-cycle pulse when the new divisor is applied.
- div_err  out  1  one-cycle pulse, the cycle after a rejected load.
- clk_div  out  1  divided clock, registered.
- tick  out  1  one-cycle pulse on the first clk cycle of each clk_div high phase.
- busy  out  1  high while state != IDLE.
- cur_div  out  CNT_W  divisor currently in force.

Behaviour:
- Reset (synchronous, rst=1 at a clk edge) sets:
  - state=IDLE, counter=0, cur_div=DEFAULT_DIV, no pending load;
  - clk_div=0, tick=0, div_ack=0, div_err=0, busy=0.
  - Reset mid-period aborts immediately; a pending load is discarded.
- Phase lengths for divisor N:
  - hi_len = ceil(N/2), lo_len = floor(N/2);
  - N=2 gives 1/1; N=5 gives 3 high / 2 low.
- States:
  - IDLE: clk_div=0. If en=1 (or START_EN after reset), go to HIGH next cycle with counter=0.
  - HIGH: clk_div=1. counter increments; at counter==hi_len-1, go to LOW with counter=0.
  - LOW: clk_div=0. counter increments; at counter==lo_len-1 the period boundary occurs:
    - apply the pending divisor, if any;
    - go to HIGH if en=1, else IDLE.
- Latency:
  - en rising in IDLE gives clk_div=1 one cycle later, tick asserted the same cycle.
  - Output period is exactly N clk cycles while running.
- en deassertion mid-period:
  - the current period completes; no truncated pulse.
  - IDLE is entered at the boundary.
- Load handshake:
  - div_load=1 with div_val >= 2: latch into the pending register.
  - div_load=1 with div_val < 2: pending is unchanged, div_err=1 the next cycle.
  - Load in IDLE: applied next cycle; div_ack is pulsed that cycle.
  - Load while running: applied at the next period boundary; div_ack is pulsed the cycle cur_div updates.
  - Multiple loads before a boundary: last valid one wins, and only one div_ack is issued.
  - Load on the boundary cycle itself: takes effect at the following boundary.
- Counter wrap: impossible by construction, since hi_len-1 <= 2^(CNT_W-1)-1.
- Simultaneous rst and div_load: rst wins.

Optional Feature:
- Macro DIV_PROG_PERIOD_CNT_EN.
- When defined:
  - adds output `period_cnt[31:0]`;
  - increments once per completed period (at the LOW→HIGH/IDLE boundary);
  - wraps 0xFFFFFFFF→0;
  - cleared by rst;
  - adds input `period_clr` (synchronous clear; clear wins over increment).
- When undefined: neither port exists and no counter logic is present.

Decomposition:
- Package div_pkg holds:
  - state enum div_state_t {IDLE, HIGH, LOW};
  - constant MIN_DIV=2;
  - function half_lengths(N) returning hi_len/lo_len.
- One sub-module, div_prog_ctrl_reg, holds:
  - the pending/current divisor registers;
  - validation and div_ack/div_err generation.
- The top instantiates div_prog_ctrl_reg and holds the FSM and counter.

Test Plan:
- Reset then en=1, default N=50 → clk_div 25 high / 25 low, tick every 50 cycles, cur_div=50.
- Load N=5 while running → at next boundary div_ack=1, then 3 high / 2 low repeating, period 5.
- Load div_val=1, then 0 → div_err pulses each time, cur_div unchanged, waveform undisturbed.
- Loads N=4, then N=8 within one period → single div_ack, cur_div=8, next period 4/4.
- en dropped 2 cycles into HIGH with N=10 → clk_div stays high 5, low 5, then IDLE with busy=0.
- rst mid-HIGH with pending N=6 → next cycle clk_div=0, cur_div=50, no div_ack; with DIV_PROG_PERIOD_CNT_EN also check period_cnt=0.
